// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one 1-cycle-latency synchronous memory between
// NUM_CORES cores (round-robin req/ack) and the com port (direct path in com mode).
module dm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int SEL_W     = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    status,
    input  logic [DATA_W-1:0]             com_data_in,
    input  logic [ADDR_W-1:0]             com_addr,
    input  logic                          com_wr_en,
    output logic [DATA_W-1:0]             com_data_out,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_wr_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_data_in,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          busy,
    output logic [SEL_W-1:0]              active_core,
    output logic [ADDR_W-1:0]             DM_addr,
    output logic [DATA_W-1:0]             DM_data_in,
    output logic                          DM_write_en,
    input  logic [DATA_W-1:0]             DM_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [SEL_W-1:0]    rr_ptr_q;
    logic [SEL_W-1:0]    active_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                wr_q;

    logic [ADDR_W-1:0]   req_addr [NUM_CORES];
    logic [DATA_W-1:0]   req_data [NUM_CORES];
    logic [NUM_CORES-1:0] cand_mask;
    logic                grant_vld_d;
    logic [SEL_W-1:0]    grant_idx_d;
    logic [SEL_W:0]      scan_sum;
    logic                run_mode;
    logic                com_path;
    logic                take_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign req_addr[gi] = core_addr[gi*ADDR_W +: ADDR_W];
            assign req_data[gi] = core_data_in[gi*DATA_W +: DATA_W];
            assign core_ack[gi] = (state_q == RESP) && (active_q == SEL_W'(gi));
        end
    endgenerate

    // In RESP the core being acked still holds req, so mask it out of the scan.
    assign cand_mask = core_req & ~core_ack;

    // Scan downwards so the last hit is the one nearest to rr_ptr+1.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        scan_sum    = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (scan_sum >= (SEL_W+1)'(NUM_CORES))
                scan_sum = scan_sum - (SEL_W+1)'(NUM_CORES);
            if (cand_mask[scan_sum[SEL_W-1:0]]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = scan_sum[SEL_W-1:0];
            end
        end
    end

    assign run_mode   = (status == 2'b01);
    assign com_path   = (state_q == IDLE) && (status == 2'b00);
    assign take_grant = grant_vld_d && run_mode &&
                        ((state_q == IDLE) || (state_q == RESP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= SEL_W'(NUM_CORES - 1);
            active_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (take_grant) begin
                        addr_q   <= req_addr[grant_idx_d];
                        data_q   <= req_data[grant_idx_d];
                        wr_q     <= core_wr_en[grant_idx_d];
                        active_q <= grant_idx_d;
                        rr_ptr_q <= grant_idx_d;
                        state_q  <= ACCESS;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                ACCESS:  state_q <= RESP;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DM_addr      = com_path ? com_addr    : addr_q;
    assign DM_data_in   = com_path ? com_data_in : data_q;
    assign DM_write_en  = com_path ? com_wr_en   : ((state_q == ACCESS) && wr_q);
    assign com_data_out = DM_out;
    assign core_rdata   = DM_out;
    assign busy         = (state_q != IDLE);
    assign active_core  = active_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a behavioural 1-cycle memory plus
// expected acks queued in grant order and compared as the DUT acks.
module tb_dm_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      status;
    logic [DW-1:0]   com_data_in;
    logic [AW-1:0]   com_addr;
    logic            com_wr_en;
    logic [DW-1:0]   com_data_out;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_wr_en;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_data_in;
    logic [N-1:0]    core_ack;
    logic [DW-1:0]   core_rdata;
    logic            busy;
    logic [SW-1:0]   active_core;
    logic [AW-1:0]   DM_addr;
    logic [DW-1:0]   DM_data_in;
    logic            DM_write_en;
    logic [DW-1:0]   DM_out = '0;

    dm_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .status(status),
        .com_data_in(com_data_in), .com_addr(com_addr), .com_wr_en(com_wr_en),
        .com_data_out(com_data_out),
        .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_data_in(core_data_in), .core_ack(core_ack), .core_rdata(core_rdata),
        .busy(busy), .active_core(active_core),
        .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_write_en(DM_write_en),
        .DM_out(DM_out)
    );

    typedef struct {
        int          core;
        logic [15:0] data;
        bit          wr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    int          n_chk = 0;
    int          n_fail = 0;
    int          pend [N];
    int          cyc = 0;
    int          last_ack = -1;
    bit          gap_en = 1'b0;
    int          wr_pulses = 0;
    logic [15:0] wr_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Memory model: registered read, read-old on simultaneous write.
    initial forever begin
        @(posedge clk);
        DM_out <= mem[DM_addr[7:0]];
        if (DM_write_en) mem[DM_addr[7:0]] = DM_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int c, input logic [15:0] a, input logic [15:0] d, input bit w);
        core_addr[c*AW +: AW]    = a;
        core_data_in[c*DW +: DW] = d;
        core_wr_en[c]            = w;
    endtask

    task automatic push_exp(input int c);
        exp_t        e;
        logic [15:0] a;
        a      = core_addr[c*AW +: AW];
        e.core = c;
        e.wr   = core_wr_en[c];
        e.data = ref_mem[a[7:0]];
        if (e.wr) ref_mem[a[7:0]] = core_data_in[c*DW +: DW];
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && sb.size() > 0; n++) tick;
        chk("drain", sb.size(), 0);
        tick;
        tick;
    endtask

    // Ack monitor: pops the scoreboard and retires core requests.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (DM_write_en) begin
                wr_pulses++;
                wr_addr_seen = DM_addr;
                wr_data_seen = DM_data_in;
            end
            if (core_ack != '0) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(core_ack), 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_core", 32'(core_ack), 32'(1) << e.core);
                    if (!e.wr) chk("rdata", 32'(core_rdata), 32'(e.data));
                    if (gap_en && last_ack >= 0) chk("ack_gap", cyc - last_ack, 2);
                    last_ack = cyc;
                    $display("ack core %0d wr=%0d rdata=%h cycle=%0d", e.core, e.wr, core_rdata, cyc);
                end
                for (int i = 0; i < N; i++) begin
                    if (core_ack[i] && pend[i] > 0) begin
                        pend[i]--;
                        if (pend[i] == 0) core_req[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        status = 2'b01; com_data_in = '0; com_addr = '0; com_wr_en = 1'b0;
        core_req = '0; core_wr_en = '0; core_addr = '0; core_data_in = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 7 + 16'h1000);
            ref_mem[i] = 16'(i * 7 + 16'h1000);
        end
        mem[8'h40] = 16'h1234; ref_mem[8'h40] = 16'h1234;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(core_ack), 0);
        chk("rst_we", 32'(DM_write_en), 0);
        chk("rst_addr", 32'(DM_addr), 0);
        chk("rst_active", 32'(active_core), 0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // Round robin from reset: order 0,1,2,3,0, two cycles apart, no writes
        for (int i = 0; i < N; i++) set_core(i, 16'(16'h20 + i), 16'h0, 1'b0);
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        gap_en = 1'b1; last_ack = -1; wr_pulses = 0;
        core_req = 4'b1111;
        wait_drain(40);
        gap_en = 1'b0;
        chk("rr_no_write", wr_pulses, 0);

        // Write then read
        wr_pulses = 0;
        set_core(1, 16'h0005, 16'h00AA, 1'b1);
        pend[1] = 1; push_exp(1); core_req[1] = 1'b1;
        wait_drain(20);
        chk("wr_pulses", wr_pulses, 1);
        chk("wr_addr", 32'(wr_addr_seen), 32'h5);
        chk("wr_data", 32'(wr_data_seen), 32'hAA);
        set_core(3, 16'h0005, 16'h0, 1'b0);
        pend[3] = 1; push_exp(3); core_req[3] = 1'b1;
        wait_drain(20);
        chk("rd_no_write", wr_pulses, 1);

        // Single core read, cycle-exact
        set_core(2, 16'h0040, 16'h0, 1'b0);
        pend[2] = 1; push_exp(2); core_req[2] = 1'b1;
        tick;
        chk("sr_busy_acc", 32'(busy), 1);
        chk("sr_addr", 32'(DM_addr), 32'h40);
        chk("sr_active", 32'(active_core), 2);
        chk("sr_we", 32'(DM_write_en), 0);
        tick;
        chk("sr_ack", 32'(core_ack), 32'b0100);
        chk("sr_rdata", 32'(core_rdata), 32'h1234);
        chk("sr_busy_resp", 32'(busy), 1);
        tick;
        chk("sr_busy_done", 32'(busy), 0);
        chk("sr_ack_done", 32'(core_ack), 0);
        chk("sr_drain", sb.size(), 0);

        // Com mode
        status = 2'b00; core_req = 4'b1111; wr_pulses = 0;
        com_addr = 16'h0010; com_data_in = 16'hBEEF; com_wr_en = 1'b1;
        ref_mem[8'h10] = 16'hBEEF;
        #1;
        chk("com_we", 32'(DM_write_en), 1);
        chk("com_addr", 32'(DM_addr), 32'h10);
        chk("com_wdata", 32'(DM_data_in), 32'hBEEF);
        tick;
        com_wr_en = 1'b0;
        #1;
        chk("com_we_off", 32'(DM_write_en), 0);
        tick;
        chk("com_rd", 32'(com_data_out), 32'hBEEF);
        chk("com_pulses", wr_pulses, 1);
        com_addr = 16'h0040;
        tick;
        chk("com_rd2", 32'(com_data_out), 32'h1234);
        chk("com_no_ack", 32'(core_ack), 0);
        chk("com_idle", 32'(busy), 0);
        core_req = '0;

        // Mode change during ACCESS: core 0 completes, core 1 stays ungranted
        status = 2'b01;
        set_core(0, 16'h0021, 16'h0, 1'b0);
        set_core(1, 16'h0022, 16'h0, 1'b0);
        pend[0] = 1; pend[1] = 0; push_exp(0);
        com_addr = 16'h0077; com_data_in = 16'hDEAD;
        core_req = 4'b0011;
        tick;
        status = 2'b00; com_wr_en = 1'b1;
        #1;
        chk("mc_busy", 32'(busy), 1);
        chk("mc_we", 32'(DM_write_en), 0);
        chk("mc_addr", 32'(DM_addr), 32'h21);
        tick;
        chk("mc_ack", 32'(core_ack), 32'b0001);
        chk("mc_we_resp", 32'(DM_write_en), 0);
        com_wr_en = 1'b0;
        tick;
        chk("mc_idle", 32'(busy), 0);
        chk("mc_com_addr", 32'(DM_addr), 32'h77);
        repeat (3) tick;
        chk("mc_no_grant", 32'(busy), 0);
        chk("mc_no_ack", 32'(core_ack), 0);
        chk("mc_drain", sb.size(), 0);
        core_req = '0; status = 2'b01;
        tick;

        // Async reset during a write ACCESS
        set_core(2, 16'h0060, 16'h5555, 1'b1);
        pend[2] = 1; core_req[2] = 1'b1;
        tick;
        chk("ar_we_before", 32'(DM_write_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", 32'(DM_write_en), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_ack", 32'(core_ack), 0);
        core_req = '0; pend[2] = 0;
        @(negedge clk) rst_n = 1'b1;
        tick;
        set_core(0, 16'h0060, 16'h0, 1'b0);
        set_core(1, 16'h0041, 16'h0, 1'b0);
        pend[0] = 1; pend[1] = 1;
        push_exp(0); push_exp(1);
        core_req = 4'b0011;
        wait_drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Parametrised successor to the single-core data-memory selector.
- Shares one synchronous data memory (1-cycle read latency) between NUM_CORES processor cores and the external com port.
- Run mode: round-robin arbitration with a req/ack handshake per core. Com mode: the com port gets a direct combinational path for program/data load and readback.
- Sits between the processor array and the data memory in the multi-core top level.

Parameters:
- NUM_CORES, 4, number of core request channels (2..16).
- DATA_W, 16, data width.
- ADDR_W, 16, data-memory address width.
- SEL_W, $clog2(NUM_CORES), width of the granted-core index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- status  in  2  2'b00 com mode; 2'b01 run mode; 2'b1x halt, no new grants.
- com_data_in  in  DATA_W  com write data.
- com_addr  in  ADDR_W  com address.
- com_wr_en  in  1  com write strobe.
- com_data_out  out  DATA_W  DM_out, passed through.
- core_req  in  NUM_CORES  per-core access request (level).
- core_wr_en  in  NUM_CORES  per-core write flag, qualified by core_req.
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- core_data_in  in  NUM_CORES*DATA_W  packed write data.
- core_ack  out  NUM_CORES  one-hot, 1-cycle completion pulse.
- core_rdata  out  DATA_W  read data, shared; valid when any core_ack bit is high.
- busy  out  1  high in ACCESS or RESP.
- active_core  out  SEL_W  index of the core currently granted.
- DM_addr  out  ADDR_W  memory address.
- DM_data_in  out  DATA_W  memory write data.
- DM_write_en  out  1  memory write enable.
- DM_out  in  DATA_W  memory read data, valid the cycle after the address.

Behaviour:
- Reset values: state IDLE; rr_ptr = NUM_CORES-1 so core 0 has first priority; registered DM_addr/DM_data_in = 0; DM_write_en = 0; core_ack = 0; busy = 0; active_core = 0.
- Mode is sampled only in IDLE and in the last RESP cycle. A status change mid-transaction never aborts it; the new mode takes effect once the FSM returns to IDLE.
- Com mode (state IDLE, status = 00):
  - DM_addr = com_addr, DM_data_in = com_data_in, DM_write_en = com_wr_en, all combinational.
  - com_data_out = DM_out.
  - Core requests are ignored: no ack, requests stay pending.
- Outside com mode, DM_* outputs come from the transaction registers; DM_write_en is 0 except in ACCESS.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, status = 01, any core_req:
  - Winner = first requesting core scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_CORES.
  - Latch the winner's addr, data and wr_en; active_core = winner; rr_ptr = winner; go to ACCESS.
- ACCESS (1 cycle):
  - DM_addr/DM_data_in are driven from the latch.
  - DM_write_en = latched wr_en, so a write strobes for exactly one cycle.
  - Go to RESP.
- RESP (1 cycle):
  - core_ack[active_core] = 1; core_rdata = DM_out. Data is meaningless for writes but still driven.
  - The same-cycle re-arbitration rule applies, with active_core excluded, because its req is still high this cycle.
  - If a candidate exists in run mode: latch it and go directly to ACCESS (back-to-back).
  - Otherwise go to IDLE.
- Latency:
  - Read data arrives with ack 2 cycles after the grant edge.
  - Sustained throughput is one access per 2 cycles when multiple cores request.
  - A lone core re-requesting passes through IDLE: 3 cycles per access.
- Core contract: hold req/addr/data/wr_en stable until ack; req is sampled low or high afresh in the cycle after ack.
- Halt (1x): FSM stays in IDLE; DM_write_en = 0; no ack.
- Fairness: a continuously requesting core is served within NUM_CORES grants.
- Reset mid-ACCESS: DM_write_en drops asynchronously, the FSM returns to IDLE, and no ack is issued.

Test Plan:
- Com mode: status=00, com write 0xBEEF to 0x0010, then read 0x0010 -> DM_write_en pulses with com_wr_en; com_data_out=0xBEEF one cycle after address; all core_ack remain 0 despite core_req=4'b1111.
- Single core read: status=01, core 2 reads 0x0040, which holds 0x1234 -> ACCESS on the next edge; core_ack=4'b0100 with core_rdata=0x1234 two cycles after the request is sampled; busy high for 2 cycles.
- Round robin: all four cores request continuously from reset -> ack order 0,1,2,3,0 on consecutive RESP cycles 2 cycles apart; DM_write_en never asserted for cores with wr_en=0.
- Write then read: core 1 writes 0x00AA to 0x0005, then core 3 reads 0x0005 -> DM_write_en high exactly one cycle; core 3 receives 0x00AA.
- Mode change mid-transaction: status switches 01->00 during ACCESS -> current transaction completes with ack; com path becomes active only after RESP; a second pending core request receives no grant.
- Async reset: assert rst_n=0 mid-ACCESS of a write -> DM_write_en=0 immediately; after release the FSM is in IDLE, rr_ptr=NUM_CORES-1, and core 0 wins the next arbitration.
